// File: rtl/mmio_console.sv
// -----------------------------------------------------------------------------
// mmio_console
//
// Memory-mapped test/console responder that sits beside data memory on the CPU
// data bus. Software stores characters into a FIFO that drains to a host sink
// over a ready/valid stream, signals end of test through a TOHOST word, and
// can read a free-running cycle counter.
//
// Register window (16 bytes at BASE_ADDR, selected by addr_i[3:2]):
//   0 TXDATA  W: wem_i[0] pushes wd_i[7:0]            R: 0
//   1 STATUS  W: wem_i[0] & wd_i[2] clears overflow   R: {count, halt, ovf, full, empty}
//   2 TOHOST  W: full-word store with bit0=1 halts    R: {exit_code_o, halt_o}
//   3 CYCLES  W: ignored                              R: cycle counter
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   addr_i       CPU byte address (shared with dmem)
//   wd_i         store data
//   we_i         store strobe, one cycle per store
//   wem_i        byte write-enable mask
//   rd_o         combinational read data, 0 when not selected (OR-able with dmem)
//   sel_o        address falls inside the register window
//   out_valid_o  a character is available at out_data_o
//   out_ready_i  sink accepts the character this cycle
//   out_data_o   head character of the FIFO
//   halt_o       sticky end-of-test flag
//   exit_code_o  exit code captured with the halting TOHOST store
//   done_o       halted and FIFO fully drained
// -----------------------------------------------------------------------------
module mmio_console #(
    parameter int                 WIDTH      = 32,
    parameter logic [WIDTH-1:0]   BASE_ADDR  = 32'h0001_0000,
    parameter int                 FIFO_DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] addr_i,
    input  logic [WIDTH-1:0] wd_i,
    input  logic             we_i,
    input  logic [3:0]       wem_i,
    output logic [WIDTH-1:0] rd_o,
    output logic             sel_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [7:0]       out_data_o,
    output logic             halt_o,
    output logic [WIDTH-2:0] exit_code_o,
    output logic             done_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        REG_TXDATA = 2'd0,
        REG_STATUS = 2'd1,
        REG_TOHOST = 2'd2,
        REG_CYCLES = 2'd3
    } reg_e;

    // State
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q,   wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q,   rd_ptr_d;
    logic [CW-1:0]    count_q,    count_d;
    logic             overflow_q, overflow_d;
    logic             halt_q,     halt_d;
    logic [WIDTH-2:0] exit_q,     exit_d;
    logic [WIDTH-1:0] cycle_q,    cycle_d;

    // Decode
    reg_e reg_sel;
    logic wr_en;
    logic empty, full;
    logic push_req, push, pop;
    logic status_clr, tohost_wr;

    // Word-aligned registers: the low address bits carry no information here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr_i[1:0];

    assign sel_o   = (addr_i[WIDTH-1:4] == BASE_ADDR[WIDTH-1:4]);
    assign reg_sel = reg_e'(addr_i[3:2]);
    assign wr_en   = we_i & sel_o;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(FIFO_DEPTH));

    assign pop        = ~empty & out_ready_i;
    assign push_req   = wr_en & (reg_sel == REG_TXDATA) & wem_i[0];
    // A full FIFO still takes a character when the head leaves in the same cycle.
    assign push       = push_req & (~full | pop);
    assign status_clr = wr_en & (reg_sel == REG_STATUS) & wem_i[0] & wd_i[2];
    assign tohost_wr  = wr_en & (reg_sel == REG_TOHOST) & (wem_i == 4'b1111) & wd_i[0];

    // Next-state logic
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        halt_d     = halt_q;
        exit_d     = exit_q;
        cycle_d    = cycle_q + WIDTH'(1);

        // Pointers wrap naturally because FIFO_DEPTH is a power of two.
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Set and clear target different registers, so they never coincide.
        if (push_req && full && !pop) begin
            overflow_d = 1'b1;
        end else if (status_clr) begin
            overflow_d = 1'b0;
        end

        // The first halting store wins; the exit code is frozen afterwards.
        if (tohost_wr && !halt_q) begin
            halt_d = 1'b1;
            exit_d = wd_i[WIDTH-1:1];
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            halt_q     <= 1'b0;
            exit_q     <= '0;
            cycle_q    <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            halt_q     <= halt_d;
            exit_q     <= exit_d;
            cycle_q    <= cycle_d;
        end
    end

    // NOTE: the character storage has no reset; its contents are only
    // observable through valid entries, and the pointers/count are reset.
    always_ff @(posedge clk_i) begin
        if (push && !rst_i) begin
            mem_q[wr_ptr_q] <= wd_i[7:0];
        end
    end

    // Read mux: zero outside the window so it can be ORed with dmem data.
    always_comb begin
        rd_o = '0;
        if (sel_o) begin
            unique case (reg_sel)
                REG_TXDATA: rd_o = '0;
                REG_STATUS: begin
                    rd_o[0]      = empty;
                    rd_o[1]      = full;
                    rd_o[2]      = overflow_q;
                    rd_o[3]      = halt_q;
                    rd_o[8 +: CW] = count_q;
                end
                REG_TOHOST: rd_o = {exit_q, halt_q};
                REG_CYCLES: rd_o = cycle_q;
                default:    rd_o = '0;
            endcase
        end
    end

    assign out_valid_o = ~empty;
    assign out_data_o  = mem_q[rd_ptr_q];
    assign halt_o      = halt_q;
    assign exit_code_o = exit_q;
    assign done_o      = halt_q & empty;

endmodule

// File: tb/tb_mmio_console.sv
// -----------------------------------------------------------------------------
// tb_mmio_console
//
// Self-checking bench for mmio_console. Stores update a queue-based reference
// model of the console (characters in flight, overflow, halt, exit code); a
// separate monitor pops the expected character whenever the DUT hands one to
// the sink. Inputs change on the falling edge; reads sample 1 ns later and the
// monitor samples 2 ns later.
// -----------------------------------------------------------------------------
module tb_mmio_console;

    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0001_0000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] addr_i;
    logic [31:0] wd_i;
    logic        we_i;
    logic [3:0]  wem_i;
    logic [31:0] rd_o;
    logic        sel_o;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [7:0]  out_data_o;
    logic        halt_o;
    logic [30:0] exit_code_o;
    logic        done_o;

    mmio_console #(
        .WIDTH      (32),
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .addr_i      (addr_i),
        .wd_i        (wd_i),
        .we_i        (we_i),
        .wem_i       (wem_i),
        .rd_o        (rd_o),
        .sel_o       (sel_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .halt_o      (halt_o),
        .exit_code_o (exit_code_o),
        .done_o      (done_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model
    logic [7:0]  exp_q [$];
    logic        m_ovf;
    logic        m_halt;
    logic [30:0] m_exit;
    logic [7:0]  last_pop;
    logic [7:0]  mon_exp;
    int          pop_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_status();
        int n;
        n = exp_q.size();
        return {16'h0, 8'(n), 4'h0, m_halt, m_ovf, (n == DEPTH), (n == 0)};
    endfunction

    function automatic logic m_done();
        return m_halt && (exp_q.size() == 0);
    endfunction

    // Register-map semantics applied to the model at the moment a store is issued.
    task automatic model_write(input logic [31:0] a, input logic [31:0] wd,
                               input logic [3:0] m, input logic rdy);
        logic [1:0] r;
        if (a[31:4] != BASE[31:4]) return;
        r = a[3:2];
        case (r)
            2'd0: if (m[0]) begin
                if (exp_q.size() < DEPTH || (rdy && exp_q.size() > 0))
                    exp_q.push_back(wd[7:0]);
                else
                    m_ovf = 1'b1;
            end
            2'd1: if (m[0] && wd[2]) m_ovf = 1'b0;
            2'd2: if (m == 4'hF && wd[0] && !m_halt) begin
                m_halt = 1'b1;
                m_exit = wd[31:1];
            end
            default: ;
        endcase
    endtask

    // One bus cycle: everything changes together on the falling edge.
    task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] m, input logic rdy);
        @(negedge clk_i);
        we_i        = we;
        addr_i      = a;
        wd_i        = wd;
        wem_i       = m;
        out_ready_i = rdy;
        if (we) model_write(a, wd, m, rdy);
    endtask

    task automatic rd(input logic [31:0] a, input logic rdy, output logic [31:0] d);
        drive(1'b0, a, 32'h0, 4'h0, rdy);
        #1;
        d = rd_o;
    endtask

    task automatic idle(input int n, input logic rdy);
        repeat (n) drive(1'b0, 32'h0, 32'h0, 4'h0, rdy);
    endtask

    task automatic check_status(input string name, input logic rdy);
        logic [31:0] d;
        rd(BASE + 32'd4, rdy, d);
        check(name, d, m_status());
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        we_i  = 1'b0;
        exp_q.delete();
        m_ovf  = 1'b0;
        m_halt = 1'b0;
        m_exit = '0;
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    // Monitor: a character leaves at the next rising edge when valid & ready.
    initial begin
        forever begin
            @(negedge clk_i);
            #2;
            if (rst_i !== 1'b1 && out_valid_o === 1'b1 && out_ready_i === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL drain_extra: got char 0x%02h, expected none", out_data_o);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("drain_data", 32'(out_data_o), 32'(mon_exp));
                    last_pop = out_data_o;
                    pop_cnt++;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, c1, c2, a;
        logic [3:0]  m;
        logic        rdy;
        int          start, first_done;

        rst_i = 1'b1; we_i = 1'b0; addr_i = '0; wd_i = '0; wem_i = '0;
        out_ready_i = 1'b0;
        m_ovf = 1'b0; m_halt = 1'b0; m_exit = '0; pop_cnt = 0; last_pop = '0;

        // Reset state
        do_reset();
        #1;
        check("rst_valid", 32'(out_valid_o), 32'd0);
        check("rst_halt",  32'(halt_o), 32'd0);
        check("rst_done",  32'(done_o), 32'd0);
        check_status("rst_status", 1'b0);
        check("rst_status_const", rd_o, 32'h0000_0001);

        // Two characters straight through
        start = pop_cnt;
        drive(1'b1, BASE, 32'h48, 4'h1, 1'b1);
        drive(1'b1, BASE, 32'h69, 4'h1, 1'b1);
        idle(3, 1'b1);
        check("hi_pop_count", 32'(pop_cnt - start), 32'd2);
        check("hi_last", 32'(last_pop), 32'h69);
        check_status("hi_status", 1'b1);

        // Overfill with the sink stalled
        for (int i = 0; i < 17; i++) drive(1'b1, BASE, 32'h41 + 32'(i), 4'h1, 1'b0);
        check_status("ovf_status", 1'b0);
        check("ovf_status_const", rd_o, 32'h0000_1006);
        check("ovf_valid", 32'(out_valid_o), 32'd1);
        idle(18, 1'b1);
        check("ovf_last", 32'(last_pop), 32'h50);
        check_status("ovf_sticky", 1'b1);
        drive(1'b1, BASE + 32'd4, 32'h4, 4'h1, 1'b1);
        check_status("ovf_cleared", 1'b1);

        // Full FIFO with a same-cycle pop and push
        for (int i = 0; i < DEPTH; i++) drive(1'b1, BASE, 32'($urandom_range(0, 255)), 4'h1, 1'b0);
        drive(1'b1, BASE, 32'h5A, 4'h1, 1'b1);
        check_status("full_pushpop", 1'b0);
        check("full_pushpop_const", rd_o, 32'h0000_1002);
        idle(18, 1'b1);
        check("full_last", 32'(last_pop), 32'h5A);

        // Halt while characters are still buffered
        for (int i = 0; i < 3; i++) drive(1'b1, BASE, 32'h30 + 32'(i), 4'h1, 1'b0);
        drive(1'b1, BASE + 32'd8, 32'h0000_002B, 4'hF, 1'b0);
        rd(BASE + 32'd8, 1'b0, d);
        check("tohost_read", d, {m_exit, m_halt});
        check("halt_set", 32'(halt_o), 32'd1);
        check("exit_code", 32'(exit_code_o), 32'd21);
        check("done_pending", 32'(done_o), 32'd0);
        first_done = -1;
        for (int i = 0; i < 6; i++) begin
            rd(BASE + 32'd4, 1'b1, d);
            check("done_track", 32'(done_o), 32'(m_done()));
            if (done_o === 1'b1 && first_done < 0) first_done = i;
        end
        check("done_cycle", 32'(first_done), 32'd3);
        drive(1'b1, BASE + 32'd8, 32'h1, 4'hF, 1'b1);
        rd(BASE + 32'd8, 1'b1, d);
        check("exit_frozen", 32'(exit_code_o), 32'd21);
        check("tohost_frozen", d, 32'h0000_002B);
        drive(1'b1, BASE, 32'h77, 4'h1, 1'b1);
        idle(3, 1'b1);
        check("post_halt_char", 32'(last_pop), 32'h77);
        check("post_halt_done", 32'(done_o), 32'd1);

        // Cycle counter
        rd(BASE + 32'd12, 1'b1, c1);
        idle(99, 1'b1);
        rd(BASE + 32'd12, 1'b1, c2);
        check("cycles_delta", c2 - c1, 32'd100);
        @(negedge clk_i);
        force dut.cycle_q = 32'hFFFF_FFFF;
        #1;
        release dut.cycle_q;
        rd(BASE + 32'd12, 1'b1, d);
        check("cycles_wrap", d, 32'h0);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            int op;
            op  = $urandom_range(0, 9);
            rdy = ($urandom_range(0, 2) != 0);
            m   = 4'($urandom_range(0, 15));
            if (op <= 3) begin
                drive(1'b1, BASE, $urandom, m | 4'h1, rdy);
            end else if (op == 4) begin
                drive(1'b1, BASE + 32'd4, $urandom, m, rdy);
            end else if (op == 5) begin
                a = ($urandom_range(0, 1) != 0) ? BASE + 32'h10 : BASE - 32'd4;
                drive(1'b1, a, $urandom, 4'h1, rdy);
            end else if (op == 6) begin
                drive(1'b1, BASE + 32'd8, $urandom, ($urandom_range(0, 3) == 0) ? 4'hF : m, rdy);
            end else begin
                int r;
                r = $urandom_range(0, 3);
                a = (r == 3) ? BASE + 32'h20 : BASE + 32'(r * 4);
                rd(a, rdy, d);
                check("rand_sel", 32'(sel_o), (r == 3) ? 32'd0 : 32'd1);
                check("rand_done", 32'(done_o), 32'(m_done()));
                case (r)
                    0:       check("rand_txdata", d, 32'h0);
                    1:       check("rand_status", d, m_status());
                    2:       check("rand_tohost", d, {m_exit, m_halt});
                    default: check("rand_outside", d, 32'h0);
                endcase
            end
        end
        idle(DEPTH + 4, 1'b1);
        check("rand_drained", 32'(exp_q.size()), 32'd0);
        check_status("rand_status_end", 1'b1);

        // Reset mid-drain with halt set
        do_reset();
        for (int i = 0; i < 5; i++) drive(1'b1, BASE, 32'h61 + 32'(i), 4'h1, 1'b0);
        drive(1'b1, BASE + 32'd8, 32'h3, 4'hF, 1'b0);
        idle(1, 1'b0);
        do_reset();
        #1;
        check("rst2_valid", 32'(out_valid_o), 32'd0);
        check("rst2_halt",  32'(halt_o), 32'd0);
        check_status("rst2_status", 1'b1);
        check("rst2_status_const", rd_o, 32'h0000_0001);
        drive(1'b1, BASE + 32'h10, 32'h55, 4'h1, 1'b1);
        #1;
        check("outside_sel", 32'(sel_o), 32'd0);
        check("outside_rd",  rd_o, 32'h0);
        idle(1, 1'b1);
        #1;
        check("outside_no_push", 32'(out_valid_o), 32'd0);
        check_status("outside_status", 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
